// File: rtl/multi_step_grader_pkg.sv
// ----------------------------------------------------------------------------
// multi_step_grader_pkg
// Shared definitions for the multi-step grader:
//   - status bus encodings (ST_IDLE / ST_RUN / ST_REJ / ST_APR)
//   - FSM state enumeration
//   - clog2_min1(): $clog2 clamped to a minimum of 1 bit, so that counters
//     sized from parameters never collapse to zero-width vectors
// ----------------------------------------------------------------------------
package multi_step_grader_pkg;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_REJ  = 2'b10;
    localparam logic [1:0] ST_APR  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_REJECT,
        S_APPROVE
    } state_e;

    function automatic int clog2_min1(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : multi_step_grader_pkg

// File: rtl/multi_step_grader_if.sv
// ----------------------------------------------------------------------------
// multi_step_grader_if
// Bundles the grader's user-input and status-bus signals.
//   Parameters: STEP_W (width of step), CNT_W (width of the tallies)
//   Inputs to the grader : valid, pass, clear_cnt
//   Outputs of the grader: status[1:0], step, done, timed_out,
//                          approve_cnt, reject_cnt
//   modport master : the side that drives valid/pass/clear_cnt
//   modport slave  : the grader itself
// ----------------------------------------------------------------------------
interface multi_step_grader_if #(
    parameter int STEP_W = 1,
    parameter int CNT_W  = 4
);

    logic              valid;
    logic              pass;
    logic              clear_cnt;
    logic [1:0]        status;
    logic [STEP_W-1:0] step;
    logic              done;
    logic              timed_out;
    logic [CNT_W-1:0]  approve_cnt;
    logic [CNT_W-1:0]  reject_cnt;

    modport master (
        output valid, pass, clear_cnt,
        input  status, step, done, timed_out, approve_cnt, reject_cnt
    );

    modport slave (
        input  valid, pass, clear_cnt,
        output status, step, done, timed_out, approve_cnt, reject_cnt
    );

endinterface : multi_step_grader_if

// File: rtl/grader_sat_counter.sv
// ----------------------------------------------------------------------------
// grader_sat_counter
// Saturating up-counter used for the verdict tallies.
//   clk    : system clock, rising edge
//   rst_n  : synchronous active-low reset
//   inc    : add one (ignored once the counter is at all-ones)
//   clr    : synchronous clear, takes priority over inc
//   count  : current count, WIDTH bits
// ----------------------------------------------------------------------------
module grader_sat_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;

    // NOTE: state is updated with non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;

endmodule : grader_sat_counter

// File: rtl/multi_step_grader.sv
// ----------------------------------------------------------------------------
// multi_step_grader
// After a start token, evaluates N_STEPS consecutive pass/fail checks and
// holds an APPROVED or REJECTED verdict on the status bus for HOLD_CYCLES
// cycles. Gaps (valid low) during a run either abort silently
// (ABORT_ON_GAP=1) or are tolerated until TIMEOUT consecutive gap cycles,
// which rejects with timed_out set. Verdicts are tallied in saturating
// counters that clear_cnt zeroes.
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : multi_step_grader_if.slave
//           in : valid, pass, clear_cnt
//           out: status, step, done, timed_out, approve_cnt, reject_cnt
// All outputs are registered.
// ----------------------------------------------------------------------------
module multi_step_grader
    import multi_step_grader_pkg::*;
#(
    parameter int N_STEPS      = 2,
    parameter int HOLD_CYCLES  = 1,
    parameter int ABORT_ON_GAP = 1,
    parameter int TIMEOUT      = 15,
    parameter int CNT_W        = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    multi_step_grader_if.slave  bus
);

    localparam int STEP_W = clog2_min1(N_STEPS);
    localparam int GAP_W  = clog2_min1(TIMEOUT + 1);
    localparam int HOLD_W = clog2_min1(HOLD_CYCLES);

    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(N_STEPS - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [GAP_W-1:0]  GAP_LIMIT = GAP_W'(TIMEOUT);

    generate
        if (N_STEPS < 1 || HOLD_CYCLES < 1 || TIMEOUT < 1) begin : g_bad_param
            $error("multi_step_grader: N_STEPS, HOLD_CYCLES and TIMEOUT must be >= 1");
        end
    endgenerate

    state_e            state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [1:0]        status_q, status_d;
    logic              done_q, done_d;
    logic              timed_out_q, timed_out_d;

    logic              timeout_hit;
    logic              approve_inc;
    logic              reject_inc;
    logic [GAP_W-1:0]  gap_inc;

    assign gap_inc = gap_q + 1'b1;

    // ------------------------------------------------------------------
    // State register (also registers the Moore outputs)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            step_q      <= '0;
            gap_q       <= '0;
            hold_q      <= '0;
            status_q    <= ST_IDLE;
            done_q      <= 1'b0;
            timed_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            gap_q       <= gap_d;
            hold_q      <= hold_d;
            status_q    <= status_d;
            done_q      <= done_d;
            timed_out_q <= timed_out_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: every signal written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        gap_d       = gap_q;
        hold_d      = hold_q;
        timeout_hit = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // pass is deliberately ignored on the start token
                if (bus.valid) begin
                    state_d = S_RUN;
                    step_d  = '0;
                    gap_d   = '0;
                end
            end

            S_RUN: begin
                if (bus.valid) begin
                    gap_d = '0;
                    if (!bus.pass) begin
                        state_d = S_REJECT;
                    end else if (step_q == STEP_LAST) begin
                        state_d = S_APPROVE;
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end else if (ABORT_ON_GAP != 0) begin
                    state_d = S_IDLE;
                    step_d  = '0;
                    gap_d   = '0;
                end else if (gap_inc == GAP_LIMIT) begin
                    // This gap sample is the TIMEOUT-th in a row
                    state_d     = S_REJECT;
                    timeout_hit = 1'b1;
                    gap_d       = '0;
                end else begin
                    gap_d = gap_inc;
                end
            end

            S_REJECT, S_APPROVE: begin
                // hold_q is zero on entry; inputs are ignored while holding
                if (hold_q == HOLD_LAST) begin
                    state_d = S_IDLE;
                    step_d  = '0;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
                step_d  = '0;
                gap_d   = '0;
                hold_d  = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic (next values of the registered outputs)
    // ------------------------------------------------------------------
    always_comb begin
        approve_inc = (state_q == S_RUN) && (state_d == S_APPROVE);
        reject_inc  = (state_q == S_RUN) && (state_d == S_REJECT);
        done_d      = approve_inc || reject_inc;

        // Set on a timeout entry, then carried for the rest of the hold
        timed_out_d = (state_d == S_REJECT) &&
                      (timeout_hit || ((state_q == S_REJECT) && timed_out_q));

        unique case (state_d)
            S_IDLE:    status_d = ST_IDLE;
            S_RUN:     status_d = ST_RUN;
            S_REJECT:  status_d = ST_REJ;
            S_APPROVE: status_d = ST_APR;
            default:   status_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Verdict tallies
    // ------------------------------------------------------------------
    grader_sat_counter #(
        .WIDTH (CNT_W)
    ) u_approve_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (approve_inc),
        .clr   (bus.clear_cnt),
        .count (bus.approve_cnt)
    );

    grader_sat_counter #(
        .WIDTH (CNT_W)
    ) u_reject_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (reject_inc),
        .clr   (bus.clear_cnt),
        .count (bus.reject_cnt)
    );

    assign bus.status    = status_q;
    assign bus.step      = step_q;
    assign bus.done      = done_q;
    assign bus.timed_out = timed_out_q;

endmodule : multi_step_grader

// File: tb/tb_multi_step_grader.sv
// ----------------------------------------------------------------------------
// tb_multi_step_grader
// Directed bench for multi_step_grader. Four instances with different
// parameter sets share clk and rst_n:
//   u_def  : defaults (N_STEPS=2, HOLD=1, ABORT_ON_GAP=1, CNT_W=4)
//   u_gap  : N_STEPS=4, ABORT_ON_GAP=0, TIMEOUT=3
//   u_hold : HOLD_CYCLES=3
//   u_cnt  : CNT_W=2
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_multi_step_grader;

    logic clk;
    logic rst_n;

    int n_vec;
    int n_err;

    multi_step_grader_if #(.STEP_W(1), .CNT_W(4)) d_if ();
    multi_step_grader_if #(.STEP_W(2), .CNT_W(4)) g_if ();
    multi_step_grader_if #(.STEP_W(1), .CNT_W(4)) h_if ();
    multi_step_grader_if #(.STEP_W(1), .CNT_W(2)) c_if ();

    multi_step_grader u_def (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (d_if)
    );

    multi_step_grader #(
        .N_STEPS      (4),
        .ABORT_ON_GAP (0),
        .TIMEOUT      (3)
    ) u_gap (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (g_if)
    );

    multi_step_grader #(
        .HOLD_CYCLES (3)
    ) u_hold (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (h_if)
    );

    multi_step_grader #(
        .CNT_W (2)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (c_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        d_if.valid = 1'b0; d_if.pass = 1'b0; d_if.clear_cnt = 1'b0;
        g_if.valid = 1'b0; g_if.pass = 1'b0; g_if.clear_cnt = 1'b0;
        h_if.valid = 1'b0; h_if.pass = 1'b0; h_if.clear_cnt = 1'b0;
        c_if.valid = 1'b0; c_if.pass = 1'b0; c_if.clear_cnt = 1'b0;

        // ---------------- reset state ----------------
        tick(2);
        check("rst status",    d_if.status,      2'b00);
        check("rst step",      d_if.step,        0);
        check("rst done",      d_if.done,        0);
        check("rst timed_out", d_if.timed_out,   0);
        check("rst apr_cnt",   d_if.approve_cnt, 0);
        check("rst rej_cnt",   d_if.reject_cnt,  0);
        rst_n = 1'b1;
        tick();
        check("idle stays", d_if.status, 2'b00);

        // ---------------- defaults: approve ----------------
        d_if.valid = 1'b1; d_if.pass = 1'b0;   // pass ignored on start
        tick();
        check("apr start status", d_if.status, 2'b01);
        check("apr start step",   d_if.step,   0);
        d_if.pass = 1'b1;
        tick();
        check("apr step1 status", d_if.status, 2'b01);
        check("apr step1 step",   d_if.step,   1);
        tick();
        check("apr verdict",   d_if.status,      2'b11);
        check("apr done",      d_if.done,        1);
        check("apr cnt",       d_if.approve_cnt, 1);
        check("apr timed_out", d_if.timed_out,   0);
        d_if.valid = 1'b0;
        tick();
        check("apr back idle", d_if.status, 2'b00);
        check("apr done drop", d_if.done,   0);
        check("apr step zero", d_if.step,   0);

        // ---------------- defaults: reject, then abort ----------------
        d_if.valid = 1'b1; d_if.pass = 1'b1;
        tick();
        check("rej start", d_if.status, 2'b01);
        d_if.pass = 1'b0;
        tick();
        check("rej verdict",   d_if.status,     2'b10);
        check("rej done",      d_if.done,       1);
        check("rej timed_out", d_if.timed_out,  0);
        check("rej cnt",       d_if.reject_cnt, 1);
        d_if.valid = 1'b0;
        tick();
        check("rej idle", d_if.status, 2'b00);
        d_if.valid = 1'b1; d_if.pass = 1'b1;
        tick();
        tick();
        check("abort pre step", d_if.step, 1);
        d_if.valid = 1'b0;
        tick();
        check("abort status",  d_if.status,      2'b00);
        check("abort done",    d_if.done,        0);
        check("abort step",    d_if.step,        0);
        check("abort apr_cnt", d_if.approve_cnt, 1);
        check("abort rej_cnt", d_if.reject_cnt,  1);

        // ---------------- gap tolerant: timeout ----------------
        g_if.valid = 1'b1;
        tick();
        check("to start", g_if.status, 2'b01);
        g_if.valid = 1'b0;
        tick(2);
        check("to gap2 status", g_if.status, 2'b01);
        tick();
        check("to verdict",   g_if.status,     2'b10);
        check("to timed_out", g_if.timed_out,  1);
        check("to done",      g_if.done,       1);
        check("to rej_cnt",   g_if.reject_cnt, 1);
        tick();
        check("to idle",     g_if.status,    2'b00);
        check("to tout clr", g_if.timed_out, 0);

        // ---------------- gap tolerant: gaps then approve ----------------
        g_if.valid = 1'b1; g_if.pass = 1'b0;
        tick();
        check("gp step0", g_if.step, 0);
        g_if.valid = 1'b0;
        tick(2);
        check("gp gap2 status", g_if.status, 2'b01);
        g_if.valid = 1'b1; g_if.pass = 1'b1;
        tick();
        check("gp step1", g_if.step, 1);
        g_if.valid = 1'b0;
        tick(2);   // gap counter must have been cleared by the pass
        check("gp regap status", g_if.status, 2'b01);
        g_if.valid = 1'b1;
        tick();
        check("gp step2", g_if.step, 2);
        tick();
        check("gp step3", g_if.step, 3);
        tick();
        check("gp verdict",   g_if.status,      2'b11);
        check("gp done",      g_if.done,        1);
        check("gp timed_out", g_if.timed_out,   0);
        check("gp apr_cnt",   g_if.approve_cnt, 1);
        g_if.valid = 1'b0;
        tick();
        check("gp idle", g_if.status, 2'b00);

        // ---------------- hold of 3 with valid held high ----------------
        h_if.valid = 1'b1; h_if.pass = 1'b1;
        tick(2);
        check("hd run", h_if.status, 2'b01);
        tick();
        check("hd h1 status", h_if.status, 2'b11);
        check("hd h1 done",   h_if.done,   1);
        tick();
        check("hd h2 status", h_if.status, 2'b11);
        check("hd h2 done",   h_if.done,   0);
        tick();
        check("hd h3 status", h_if.status, 2'b11);
        check("hd h3 done",   h_if.done,   0);
        tick();
        check("hd idle", h_if.status, 2'b00);
        tick();
        check("hd restart",      h_if.status,      2'b01);
        check("hd restart step", h_if.step,        0);
        check("hd apr_cnt",      h_if.approve_cnt, 1);
        h_if.valid = 1'b0;
        tick();
        check("hd abort", h_if.status, 2'b00);

        // ---------------- saturation and clear priority (CNT_W=2) ----------------
        c_if.valid = 1'b1; c_if.pass = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(3);
            check("sat verdict", c_if.status, 2'b11);
            check("sat apr_cnt", c_if.approve_cnt, (i + 1 > 3) ? 3 : i + 1);
            tick();
        end
        tick(2);
        c_if.clear_cnt = 1'b1;
        tick();
        check("clr verdict", c_if.status,      2'b11);
        check("clr apr_cnt", c_if.approve_cnt, 0);
        check("clr rej_cnt", c_if.reject_cnt,  0);
        c_if.clear_cnt = 1'b0; c_if.valid = 1'b0;
        tick();
        check("clr idle",     c_if.status,      2'b00);
        check("clr apr_cnt2", c_if.approve_cnt, 0);

        // ---------------- reset mid-run ----------------
        d_if.valid = 1'b1; d_if.pass = 1'b1;
        tick(2);
        check("rr pre step", d_if.step, 1);
        rst_n = 1'b0;   // without reset this edge would approve
        tick();
        check("rr status",  d_if.status,      2'b00);
        check("rr step",    d_if.step,        0);
        check("rr done",    d_if.done,        0);
        check("rr apr_cnt", d_if.approve_cnt, 0);
        check("rr rej_cnt", d_if.reject_cnt,  0);
        rst_n = 1'b1; d_if.valid = 1'b0;
        tick();
        check("rr idle", d_if.status, 2'b00);

        // ---------------- reset during approve hold ----------------
        h_if.valid = 1'b1; h_if.pass = 1'b1;
        tick(3);
        check("rh in hold", h_if.status, 2'b11);
        rst_n = 1'b0;
        tick();
        check("rh status",  h_if.status,      2'b00);
        check("rh done",    h_if.done,        0);
        check("rh apr_cnt", h_if.approve_cnt, 0);
        rst_n = 1'b1; h_if.valid = 1'b0;
        tick();
        check("rh idle", h_if.status, 2'b00);

        // ---------------- reset during timeout hold ----------------
        g_if.valid = 1'b1;
        tick();
        g_if.valid = 1'b0;
        tick(3);
        check("rt timed_out", g_if.timed_out, 1);
        rst_n = 1'b0;
        tick();
        check("rt status",    g_if.status,     2'b00);
        check("rt tout zero", g_if.timed_out,  0);
        check("rt rej_cnt",   g_if.reject_cnt, 0);
        rst_n = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_multi_step_grader
